// File: rtl/decomp_pkg.sv
// ---------------------------------------------------------------------------
// decomp_pkg
// Shared constants, state type and helpers for the decompression output
// packer.
//   DATA_BYTES      : bytes per c2s output beat (tdata = 8*DATA_BYTES bits)
//   ACC_BYTES       : accumulator depth in bytes, two beats deep
//   CNT_W           : width of byte counters, holds 0..ACC_BYTES
//   packer_state_t  : ACCUM (collecting) / FLUSH (packet end accepted)
//   keep_from_count : contiguous byte-enable mask with the low n bits set
// ---------------------------------------------------------------------------
package decomp_pkg;

    localparam int DATA_BYTES = 32;
    localparam int ACC_BYTES  = 2 * DATA_BYTES;
    localparam int CNT_W      = 7;

    typedef enum logic {
        ACCUM = 1'b0,
        FLUSH = 1'b1
    } packer_state_t;

    // Saturates naturally: any n >= DATA_BYTES yields all ones.
    function automatic logic [DATA_BYTES-1:0] keep_from_count(input logic [CNT_W-1:0] n);
        logic [DATA_BYTES-1:0] mask;
        mask = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (CNT_W'(i) < n) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// ---------------------------------------------------------------------------
// byte_lane_merge
// Combinational next-accumulator builder for the output packer. The current
// accumulator is shifted down by the number of bytes just emitted, then the
// valid lanes of the incoming group are OR-ed in starting at byte i_base.
// Ports:
//   i_acc     : current accumulator, byte 0 is the next byte to emit
//   i_removed : bytes leaving this cycle (0 when no beat fires)
//   i_base    : byte index where new data lands (fill - removed)
//   i_insert  : an input group is accepted this cycle
//   i_data    : incoming group, lane 0 first
//   i_bytes   : number of valid lanes in i_data, already clamped
//   o_acc     : accumulator contents for the next cycle
// ---------------------------------------------------------------------------
module byte_lane_merge
    import decomp_pkg::*;
(
    input  logic [ACC_BYTES*8-1:0]  i_acc,
    input  logic [CNT_W-1:0]        i_removed,
    input  logic [CNT_W-1:0]        i_base,
    input  logic                    i_insert,
    input  logic [DATA_BYTES*8-1:0] i_data,
    input  logic [CNT_W-1:0]        i_bytes,
    output logic [ACC_BYTES*8-1:0]  o_acc
);

    logic [ACC_BYTES*8-1:0]  w_shifted;
    logic [DATA_BYTES*8-1:0] w_masked;
    logic [ACC_BYTES*8-1:0]  w_inserted;

    // Bytes above the fill level are kept at zero, so the shifted-in zeros
    // and the masked input lanes can simply be OR-ed together. Accepted
    // input only arrives while fill <= DATA_BYTES, so base + 32 never runs
    // past the top of the accumulator.
    always_comb begin
        w_shifted = i_acc >> {i_removed, 3'b000};
        w_masked  = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (CNT_W'(i) < i_bytes) begin
                w_masked[8*i +: 8] = i_data[8*i +: 8];
            end
        end
        w_inserted = {{((ACC_BYTES - DATA_BYTES) * 8){1'b0}}, w_masked} << {i_base, 3'b000};
        o_acc      = i_insert ? (w_shifted | w_inserted) : w_shifted;
    end

endmodule

// File: rtl/decomp_out_packer.sv
// ---------------------------------------------------------------------------
// decomp_out_packer
// Repacks variable-length decompressed byte groups (0..32 bytes per cycle,
// lane 0 first) into dense 256-bit AXI4-Stream beats with a partial tkeep
// and tlast on the final beat of each packet.
// Ports:
//   axis_aclk / axis_aresetn : clock, asynchronous active-low reset
//   in_data, in_bytes        : input group and its valid byte count
//   in_valid, in_last        : group valid, final group of the packet
//   in_ready                 : packer accepts a group this cycle
//   axis_*_c2s               : AXI4-Stream master output
//   stat_pkts                : packets emitted (beats with tlast), wraps
// ---------------------------------------------------------------------------
module decomp_out_packer
    import decomp_pkg::*;
(
    input  logic                    axis_aclk,
    input  logic                    axis_aresetn,
    input  logic [DATA_BYTES*8-1:0] in_data,
    input  logic [5:0]              in_bytes,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic [DATA_BYTES*8-1:0] axis_tdata_c2s,
    output logic [DATA_BYTES-1:0]   axis_tkeep_c2s,
    output logic                    axis_tlast_c2s,
    output logic                    axis_tvalid_c2s,
    input  logic                    axis_tready_c2s,
    output logic [31:0]             stat_pkts
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_BYTES);

    packer_state_t          r_state;
    packer_state_t          w_stateNext;
    logic [ACC_BYTES*8-1:0] r_acc;
    logic [CNT_W-1:0]       r_fill;
    logic                   r_resetDone;
    logic [31:0]            r_statPkts;

    logic [ACC_BYTES*8-1:0] w_accNext;
    logic [CNT_W-1:0]       w_outBytes;
    logic [CNT_W-1:0]       w_inBytes;
    logic [CNT_W-1:0]       w_removed;
    logic [CNT_W-1:0]       w_base;
    logic [CNT_W-1:0]       w_fillNext;
    logic                   w_inFire;
    logic                   w_outFire;

    // State register of the packet FSM.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic: enter FLUSH when the packet's last group is taken,
    // return to ACCUM once the beat carrying tlast has been accepted.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ACCUM: if (w_inFire && in_last) w_stateNext = FLUSH;
            FLUSH: if (w_outFire && axis_tlast_c2s) w_stateNext = ACCUM;
            default: w_stateNext = ACCUM;
        endcase
    end

    // Output decode, purely from registers. r_resetDone holds in_ready low
    // during reset and for the first edge after release.
    always_comb begin
        in_ready        = r_resetDone && (r_state == ACCUM) && (r_fill <= FULL_CNT);
        axis_tvalid_c2s = (r_fill >= FULL_CNT) || (r_state == FLUSH);
        axis_tlast_c2s  = (r_state == FLUSH) && (r_fill <= FULL_CNT);
        w_outBytes      = (r_fill > FULL_CNT) ? FULL_CNT : r_fill;
        axis_tkeep_c2s  = keep_from_count(w_outBytes);
        axis_tdata_c2s  = r_acc[DATA_BYTES*8-1:0];
        stat_pkts       = r_statPkts;
    end

    // Handshakes and the fill arithmetic. Emitted bytes are removed before
    // new bytes are appended, so new data lands right after what remains.
    always_comb begin
        w_inFire   = in_valid && in_ready;
        w_outFire  = axis_tvalid_c2s && axis_tready_c2s;
        w_inBytes  = (in_bytes > 6'd32) ? FULL_CNT : {1'b0, in_bytes};
        w_removed  = w_outFire ? w_outBytes : '0;
        w_base     = r_fill - w_removed;
        w_fillNext = w_base + (w_inFire ? w_inBytes : '0);
    end

    byte_lane_merge u_merge (
        .i_acc     (r_acc),
        .i_removed (w_removed),
        .i_base    (w_base),
        .i_insert  (w_inFire),
        .i_data    (in_data),
        .i_bytes   (w_inBytes),
        .o_acc     (w_accNext)
    );

    // Accumulator, fill count, reset-release flag and packet counter.
    // Reset drops any partially collected packet without emitting it.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_acc       <= '0;
            r_fill      <= '0;
            r_resetDone <= 1'b0;
            r_statPkts  <= '0;
        end else begin
            r_acc       <= w_accNext;
            r_fill      <= w_fillNext;
            r_resetDone <= 1'b1;
            if (w_outFire && axis_tlast_c2s) begin
                r_statPkts <= r_statPkts + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_decomp_out_packer.sv
// ---------------------------------------------------------------------------
// tb_decomp_out_packer
// Self-checking bench: a byte-queue model of the packer checked every cycle,
// plus directed packets with hand-computed beat contents.
// ---------------------------------------------------------------------------
module tb_decomp_out_packer;

    logic         axis_aclk = 1'b0;
    logic         axis_aresetn;
    logic [255:0] in_data;
    logic [5:0]   in_bytes;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [255:0] axis_tdata_c2s;
    logic [31:0]  axis_tkeep_c2s;
    logic         axis_tlast_c2s;
    logic         axis_tvalid_c2s;
    logic         axis_tready_c2s;
    logic [31:0]  stat_pkts;

    typedef struct {
        logic [255:0] data;
        logic [31:0]  keep;
        logic         last;
    } beat_t;

    int          testCount = 0;
    int          failCount = 0;
    logic [7:0]  modelBytes[$];
    bit          modelLastPending = 1'b0;
    int unsigned modelPkts = 0;
    beat_t       beats[$];

    decomp_out_packer dut (
        .axis_aclk       (axis_aclk),
        .axis_aresetn    (axis_aresetn),
        .in_data         (in_data),
        .in_bytes        (in_bytes),
        .in_valid        (in_valid),
        .in_last         (in_last),
        .in_ready        (in_ready),
        .axis_tdata_c2s  (axis_tdata_c2s),
        .axis_tkeep_c2s  (axis_tkeep_c2s),
        .axis_tlast_c2s  (axis_tlast_c2s),
        .axis_tvalid_c2s (axis_tvalid_c2s),
        .axis_tready_c2s (axis_tready_c2s),
        .stat_pkts       (stat_pkts)
    );

    // 100 MHz clock.
    always #5 axis_aclk = ~axis_aclk;

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        testCount++;
        failCount++;
        $display("[TB] FAIL %s: timed out waiting for DUT", name);
    endtask

    // Expected beat image: bytes start, start+1, ... in lanes 0..n-1, zero above.
    function automatic logic [255:0] pattern(input int start, input int n);
        logic [255:0] d;
        d = '0;
        for (int k = 0; k < n; k++) begin
            d[8*k +: 8] = 8'(start + k);
        end
        return d;
    endfunction

    // Offer one group; lanes at or above n carry junk that must be ignored.
    task automatic applyStimulus(input int n, input int start, input bit last);
        int waited;
        waited = 0;
        in_valid = 1'b1;
        in_bytes = 6'(n);
        in_last  = last;
        for (int k = 0; k < 32; k++) begin
            in_data[8*k +: 8] = (k < n) ? 8'(start + k) : 8'hEE;
        end
        forever begin
            @(negedge axis_aclk);
            if (in_ready) break;
            waited++;
            if (waited > 200) begin
                reportTimeout("in_ready wait");
                break;
            end
        end
        @(posedge axis_aclk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_bytes = '0;
    endtask

    task automatic waitBeats(input int n, input string name);
        int waited;
        waited = 0;
        while (beats.size() < n && waited < 300) begin
            @(negedge axis_aclk);
            waited++;
        end
        @(posedge axis_aclk);
        #1;
        checkOutput({name, " beat count"}, 256'(beats.size()), 256'(n));
    endtask

    // Reference model: a queue of accepted bytes plus a flag saying the
    // packet end is already in the queue. Each cycle the expected beat is
    // the head of the queue; a fire consumes it, then accepted input appends.
    always @(negedge axis_aclk) begin
        int           cnt;
        int           nIn;
        bit           expValid;
        bit           expLast;
        logic [255:0] expData;
        logic [31:0]  expKeep;
        if (!axis_aresetn) begin
            modelBytes.delete();
            modelLastPending = 1'b0;
            modelPkts = 0;
        end else begin
            cnt      = (modelBytes.size() > 32) ? 32 : modelBytes.size();
            expValid = (modelBytes.size() >= 32) || modelLastPending;
            expLast  = modelLastPending && (modelBytes.size() <= 32);
            expData  = '0;
            expKeep  = '0;
            for (int k = 0; k < cnt; k++) begin
                expData[8*k +: 8] = modelBytes[k];
                expKeep[k] = 1'b1;
            end
            checkOutput("tvalid", 256'(axis_tvalid_c2s), 256'(expValid));
            if (expValid) begin
                checkOutput("tdata", axis_tdata_c2s, expData);
                checkOutput("tkeep", 256'(axis_tkeep_c2s), 256'(expKeep));
                checkOutput("tlast", 256'(axis_tlast_c2s), 256'(expLast));
            end
            checkOutput("stat_pkts", 256'(stat_pkts), 256'(modelPkts));
            if (axis_tvalid_c2s && axis_tready_c2s) begin
                beats.push_back('{axis_tdata_c2s, axis_tkeep_c2s, axis_tlast_c2s});
                repeat (cnt) void'(modelBytes.pop_front());
                if (expLast) begin
                    modelLastPending = 1'b0;
                    modelPkts++;
                end
            end
            if (in_valid && in_ready) begin
                nIn = (in_bytes > 6'd32) ? 32 : int'(in_bytes);
                for (int k = 0; k < nIn; k++) begin
                    modelBytes.push_back(in_data[8*k +: 8]);
                end
                if (in_last) modelLastPending = 1'b1;
            end
        end
    end

    // Hard stop in case a directed sequence wedges.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        logic [255:0] held;

        // Reset state with in_valid asserted.
        axis_aresetn    = 1'b0;
        in_valid        = 1'b1;
        in_data         = '0;
        in_bytes        = 6'd8;
        in_last         = 1'b0;
        axis_tready_c2s = 1'b1;
        repeat (3) @(posedge axis_aclk);
        #1;
        checkOutput("reset in_ready", 256'(in_ready), 256'(0));
        checkOutput("reset tvalid", 256'(axis_tvalid_c2s), 256'(0));
        checkOutput("reset tkeep", 256'(axis_tkeep_c2s), 256'(0));
        checkOutput("reset tlast", 256'(axis_tlast_c2s), 256'(0));
        checkOutput("reset tdata", axis_tdata_c2s, 256'(0));
        checkOutput("reset stat_pkts", 256'(stat_pkts), 256'(0));
        @(negedge axis_aclk);
        axis_aresetn = 1'b1;
        #1;
        checkOutput("release in_ready same cycle", 256'(in_ready), 256'(0));
        @(posedge axis_aclk);
        #1;
        checkOutput("release in_ready next cycle", 256'(in_ready), 256'(1));
        in_valid = 1'b0;
        in_bytes = '0;

        // Dense packing: four 16-byte groups.
        beats.delete();
        for (int g = 0; g < 4; g++) begin
            applyStimulus(16, g * 16, g == 3);
        end
        waitBeats(2, "dense");
        if (beats.size() >= 2) begin
            checkOutput("dense beat0 data", beats[0].data, pattern(8'h00, 32));
            checkOutput("dense beat1 data", beats[1].data, pattern(8'h20, 32));
            checkOutput("dense beat0 keep", 256'(beats[0].keep), 256'(32'hFFFF_FFFF));
            checkOutput("dense beat1 keep", 256'(beats[1].keep), 256'(32'hFFFF_FFFF));
            checkOutput("dense beat0 last", 256'(beats[0].last), 256'(0));
            checkOutput("dense beat1 last", 256'(beats[1].last), 256'(1));
        end
        checkOutput("dense stat_pkts", 256'(stat_pkts), 256'(1));

        // Partial tail: 20 + 20 bytes, input blocked until the tail fires.
        beats.delete();
        axis_tready_c2s = 1'b0;
        applyStimulus(20, 8'h40, 1'b0);
        applyStimulus(20, 8'h54, 1'b1);
        repeat (2) @(posedge axis_aclk);
        #1;
        checkOutput("tail flush blocks input", 256'(in_ready), 256'(0));
        axis_tready_c2s = 1'b1;
        waitBeats(2, "tail");
        checkOutput("tail in_ready after last beat", 256'(in_ready), 256'(1));
        if (beats.size() >= 2) begin
            checkOutput("tail beat0 data", beats[0].data, pattern(8'h40, 32));
            checkOutput("tail beat0 last", 256'(beats[0].last), 256'(0));
            checkOutput("tail beat1 data", beats[1].data, pattern(8'h60, 8));
            checkOutput("tail beat1 keep", 256'(beats[1].keep), 256'(32'h0000_00FF));
            checkOutput("tail beat1 last", 256'(beats[1].last), 256'(1));
        end
        checkOutput("tail stat_pkts", 256'(stat_pkts), 256'(2));

        // Backpressure: six 32-byte groups with tready held low for a while.
        beats.delete();
        axis_tready_c2s = 1'b0;
        fork
            begin
                for (int g = 0; g < 6; g++) begin
                    applyStimulus(32, g * 32, g == 5);
                end
            end
            begin
                repeat (5) @(posedge axis_aclk);
                #2;
                checkOutput("bp in_ready full", 256'(in_ready), 256'(0));
                checkOutput("bp tvalid", 256'(axis_tvalid_c2s), 256'(1));
                held = axis_tdata_c2s;
                repeat (5) @(posedge axis_aclk);
                #2;
                checkOutput("bp stall stable", axis_tdata_c2s, held);
                checkOutput("bp stall data", axis_tdata_c2s, pattern(0, 32));
                axis_tready_c2s = 1'b1;
            end
        join
        waitBeats(6, "bp");
        if (beats.size() >= 6) begin
            checkOutput("bp beat3 data", beats[3].data, pattern(96, 32));
            checkOutput("bp beat4 last", 256'(beats[4].last), 256'(0));
            checkOutput("bp beat5 data", beats[5].data, pattern(160, 32));
            checkOutput("bp beat5 keep", 256'(beats[5].keep), 256'(32'hFFFF_FFFF));
            checkOutput("bp beat5 last", 256'(beats[5].last), 256'(1));
        end
        checkOutput("bp stat_pkts", 256'(stat_pkts), 256'(3));

        // Zero-length end at fill = 0.
        beats.delete();
        applyStimulus(0, 0, 1'b1);
        waitBeats(1, "zero");
        if (beats.size() >= 1) begin
            checkOutput("zero keep", 256'(beats[0].keep), 256'(0));
            checkOutput("zero last", 256'(beats[0].last), 256'(1));
            checkOutput("zero data", beats[0].data, 256'(0));
        end
        checkOutput("zero stat_pkts", 256'(stat_pkts), 256'(4));

        // Over-length count clamps to a full group.
        beats.delete();
        applyStimulus(40, 8'hC0, 1'b1);
        waitBeats(1, "clamp");
        if (beats.size() >= 1) begin
            checkOutput("clamp data", beats[0].data, pattern(8'hC0, 32));
            checkOutput("clamp keep", 256'(beats[0].keep), 256'(32'hFFFF_FFFF));
            checkOutput("clamp last", 256'(beats[0].last), 256'(1));
        end
        checkOutput("clamp stat_pkts", 256'(stat_pkts), 256'(5));

        // Mid-packet reset discards 40 collected bytes.
        beats.delete();
        axis_tready_c2s = 1'b0;
        applyStimulus(32, 8'h10, 1'b0);
        applyStimulus(8, 8'h30, 1'b0);
        @(posedge axis_aclk);
        #2;
        axis_aresetn = 1'b0;
        #1;
        checkOutput("midreset tvalid", 256'(axis_tvalid_c2s), 256'(0));
        checkOutput("midreset tkeep", 256'(axis_tkeep_c2s), 256'(0));
        checkOutput("midreset in_ready", 256'(in_ready), 256'(0));
        checkOutput("midreset stat_pkts", 256'(stat_pkts), 256'(0));
        @(posedge axis_aclk);
        #2;
        axis_aresetn = 1'b1;
        @(posedge axis_aclk);
        #1;
        axis_tready_c2s = 1'b1;
        repeat (3) @(posedge axis_aclk);
        #1;
        checkOutput("midreset no stale beat", 256'(beats.size()), 256'(0));
        applyStimulus(8, 8'h70, 1'b1);
        waitBeats(1, "after reset");
        if (beats.size() >= 1) begin
            checkOutput("after reset data", beats[0].data, pattern(8'h70, 8));
            checkOutput("after reset keep", 256'(beats[0].keep), 256'(32'h0000_00FF));
            checkOutput("after reset last", 256'(beats[0].last), 256'(1));
        end
        checkOutput("after reset stat_pkts", 256'(stat_pkts), 256'(1));

        repeat (3) @(posedge axis_aclk);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
